morse_decode_sequencer: RTL and testbench
=========================================

Name: morse_decode_sequencer

Overview:
- Top-level controller for the Morse datapath.
- Runs calibration first, then decode mode: drives calibration start, dot/dash start, and wait-timer start/clear.
- Gathers dot and dash symbols into a letter code and presents it to the display/letter logic with a valid/ack handshake.
- Flags letter-gap and word-gap boundaries using the wait timer's Timeout pulses.

Parameters:
MAX_SYM, 5, maximum symbols per letter (1..7); sets the Letter_bits width.
WORD_GAP_TO, 3, consecutive Timeouts after a letter ends, counting the letter-ending one, that mark a word gap (2..7).

Ports:
Clk  in  1  system clock (100 MHz board clock).
Reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
Mode  in  1  0 = calibrate, 1 = decode; sampled only on Go.
Go  in  1  single-cycle pulse (debouncer SCEN); starts or aborts operation.
Cal_Done  in  1  single-cycle pulse from calibration: thresholds valid.
Dot  in  1  single-cycle pulse from dot_dash: short press classified.
Dash  in  1  single-cycle pulse from dot_dash: long press classified.
Timeout  in  1  single-cycle pulse from wait_timer: letter-gap time elapsed.
Letter_ack  in  1  consumer accepts the presented letter.
Cal_Start  out  1  level; high while in CAL.
Dec_Start  out  1  level; high in WAIT_SYM, COLLECT, EMIT, GAP; also drives wait_timer Start.
Tclear  out  1  single-cycle pulse; restarts the wait timer.
Letter_bits  out  MAX_SYM  symbol pattern, 0 = dot, 1 = dash; last symbol at bit 0, first symbol at bit Letter_len-1, unused upper bits 0.
Letter_len  out  3  number of valid symbols, 1..MAX_SYM.
Letter_valid  out  1  letter presented; held until Letter_ack.
Overflow  out  1  letter had more than MAX_SYM symbols; valid with Letter_valid.
Space_valid  out  1  single-cycle pulse on word gap.
State  out  3  encoding: IDLE 0, CAL 1, WAIT_SYM 2, COLLECT 3, EMIT 4, GAP 5 (for LEDs).

Behaviour:
- Reset (Reset=0, async):
  - State = IDLE; all outputs 0; shift register, length and gap counter = 0; internal Calibrated flag = 0.
- All outputs are registered.
- IDLE:
  - On Go with Mode=0, or with Mode=1 and Calibrated=0 → CAL.
  - On Go with Mode=1 and Calibrated=1 → WAIT_SYM, with a Tclear pulse on entry.
- CAL:
  - Cal_Start=1.
  - On Cal_Done: Calibrated ← 1, → IDLE.
  - On Go without Cal_Done: abort → IDLE; Calibrated unchanged.
  - Cal_Done and Go in the same cycle: Cal_Done wins.
- WAIT_SYM:
  - On Dot or Dash: load the symbol, len=1, Tclear pulse, → COLLECT.
  - Timeout is ignored.
- COLLECT:
  - Dot/Dash with len<MAX_SYM: shift left and insert the symbol at bit 0; len+1; Tclear pulse.
  - Dot/Dash with len=MAX_SYM: symbol dropped; Overflow ← 1; Tclear still pulses.
  - Timeout with no symbol in the same cycle → EMIT.
  - Letter_valid rises one cycle after Timeout is sampled.
- Simultaneous-event rules:
  - Dot and Dash in the same cycle: treated as a single Dash.
  - Symbol and Timeout in the same cycle: symbol wins; Timeout discarded.
- EMIT:
  - Letter_valid=1; Letter_bits, Letter_len and Overflow are stable while valid.
  - Dot, Dash and Timeout are ignored.
  - Letter_ack sampled high: next cycle Letter_valid=0, register/len/Overflow cleared, gap_cnt ← 1, → GAP.
  - Letter_ack asserted while not valid has no effect.
- GAP:
  - On Dot/Dash: start a new letter exactly as in WAIT_SYM; gap_cnt ← 0; → COLLECT.
  - On Timeout: gap_cnt+1. When the new value equals WORD_GAP_TO: Space_valid pulses for 1 cycle, gap_cnt ← 0, → WAIT_SYM.
- Go in any decode state (WAIT_SYM, COLLECT, EMIT, GAP):
  - → IDLE; register, len, Overflow and gap_cnt cleared; any pending letter discarded; Letter_valid drops next cycle.
  - Calibrated is retained.
- Width rules: gap_cnt is 3 bits and saturates logically, since it clears at WORD_GAP_TO; len never exceeds MAX_SYM.
- Reset asserted mid-operation: immediate return to the reset values above, including Calibrated=0.

Test Plan:
1. Release reset, Go with Mode=1 while uncalibrated → State=1, Cal_Start=1; Cal_Done pulse → State=0, Cal_Start=0; a second Go with Mode=1 → State=2, one-cycle Tclear.
2. Calibrated decode: Dot, Dash, Timeout → Letter_valid=1 one cycle after Timeout, Letter_bits=5'b00001 ("A"), Letter_len=2, Overflow=0; valid holds for 10 cycles until Letter_ack, then State=5.
3. Six Dash pulses then Timeout → Letter_bits=5'b11111, Letter_len=5, Overflow=1; six Tclear pulses observed.
4. After ack (gap_cnt=1), two Timeout pulses → Space_valid high for exactly 1 cycle on the second, State=2; repeat with a Dot before the second Timeout → no Space_valid, State=3, len=1.
5. In COLLECT with len=1, Dot and Timeout in the same cycle → State stays 3, len=2, Tclear pulses; Dot+Dash together → single dash appended.
6. Reset driven low while State=4 → Letter_valid=0 asynchronously, State=0; after release, Go with Mode=1 → CAL (calibration was lost).

Source files
------------

// File: rtl/morse_decode_sequencer.sv
// -----------------------------------------------------------------------------
// morse_decode_sequencer
//
// Top-level controller for the Morse datapath. After reset it must calibrate
// once; after that a Go with Mode=1 enters decode mode. In decode mode it
// collects dot/dash symbols into a letter code and presents each letter with
// a valid/ack handshake. It also uses the wait timer's Timeout pulses to find
// the gap at the end of a letter and the longer gap between words.
//
// Parameters
//   MAX_SYM      maximum symbols kept per letter (1..7); width of Letter_bits
//   WORD_GAP_TO  Timeouts after a letter ends, counting the letter-ending one,
//                that make a word gap (2..7)
//
// Ports
//   Clk           in   system clock
//   Reset         in   asynchronous active-low reset
//   Mode          in   0 = calibrate, 1 = decode (sampled only on Go)
//   Go            in   single-cycle start/abort pulse
//   Cal_Done      in   calibration finished pulse
//   Dot, Dash     in   classified symbol pulses (both together = dash)
//   Timeout       in   wait-timer letter-gap pulse
//   Letter_ack    in   consumer accepts the presented letter
//   Cal_Start     out  high while calibrating
//   Dec_Start     out  high in any decode state; also the wait-timer Start
//   Tclear        out  single-cycle wait-timer restart pulse
//   Letter_bits   out  symbol pattern (1 = dash); last symbol at bit 0
//   Letter_len    out  number of valid symbols
//   Letter_valid  out  letter presented, held until Letter_ack
//   Overflow      out  letter had more than MAX_SYM symbols
//   Space_valid   out  single-cycle word-gap pulse
//   State         out  current state code for the LEDs
// -----------------------------------------------------------------------------
module morse_decode_sequencer #(
  parameter int MAX_SYM     = 5,
  parameter int WORD_GAP_TO = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Mode,
  input  logic               Go,
  input  logic               Cal_Done,
  input  logic               Dot,
  input  logic               Dash,
  input  logic               Timeout,
  input  logic               Letter_ack,
  output logic               Cal_Start,
  output logic               Dec_Start,
  output logic               Tclear,
  output logic [MAX_SYM-1:0] Letter_bits,
  output logic [2:0]         Letter_len,
  output logic               Letter_valid,
  output logic               Overflow,
  output logic               Space_valid,
  output logic [2:0]         State
);

  // State codes double as the LED encoding.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CAL      = 3'd1;
  localparam logic [2:0] ST_WAIT_SYM = 3'd2;
  localparam logic [2:0] ST_COLLECT  = 3'd3;
  localparam logic [2:0] ST_EMIT     = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam logic [2:0] MAX_LEN   = 3'(MAX_SYM);
  localparam logic [2:0] GAP_LIMIT = 3'(WORD_GAP_TO);

  logic [2:0]         state_q, state_d;
  logic               calibrated_q, calibrated_d;
  logic [MAX_SYM-1:0] bits_q, bits_d;
  logic [2:0]         len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         gap_q, gap_d;
  logic               tclear_q, tclear_d;
  logic               space_q, space_d;
  logic               cal_start_q, cal_start_d;
  logic               dec_start_q, dec_start_d;
  logic               valid_q, valid_d;

  // A simultaneous Dot and Dash counts as one dash, so the symbol value is
  // simply Dash and "any symbol" is the OR of the two pulses.
  logic sym_s;
  logic sym_bit_s;

  assign sym_s     = Dot | Dash;
  assign sym_bit_s = Dash;

  // Shift the pattern left and insert the newest symbol at bit 0.
  function automatic logic [MAX_SYM-1:0] append_sym(
    input logic [MAX_SYM-1:0] bits,
    input logic               sym
  );
    logic [MAX_SYM-1:0] res;
    res    = bits << 1;
    res[0] = sym;
    return res;
  endfunction

  // Pattern for a letter whose only symbol so far is sym.
  function automatic logic [MAX_SYM-1:0] first_sym(input logic sym);
    logic [MAX_SYM-1:0] res;
    res    = '0;
    res[0] = sym;
    return res;
  endfunction

  // Next-state logic: sequencing, symbol collection and gap counting.
  always_comb begin
    state_d      = state_q;
    calibrated_d = calibrated_q;
    bits_d       = bits_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    gap_d        = gap_q;
    tclear_d     = 1'b0;
    space_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Go) begin
          if (!Mode || !calibrated_q) begin
            state_d = ST_CAL;
          end else begin
            state_d  = ST_WAIT_SYM;
            tclear_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CAL: begin
        // Cal_Done takes priority over a coincident abort.
        if (Cal_Done) begin
          calibrated_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (Go) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CAL;
        end
      end

      ST_WAIT_SYM: begin
        if (Go) begin
          state_d = ST_IDLE;
          bits_d  = '0;
          len_d   = 3'd0;
          ovf_d   = 1'b0;
          gap_d   = 3'd0;
        end else if (sym_s) begin
          bits_d   = first_sym(sym_bit_s);
          len_d    = 3'd1;
          ovf_d    = 1'b0;
          tclear_d = 1'b1;
          state_d  = ST_COLLECT;
        end else begin
          state_d = ST_WAIT_SYM;
        end
      end

      ST_COLLECT: begin
        // A symbol beats a coincident Timeout; the timer restarts instead.
        if (Go) begin
          state_d = ST_IDLE;
          bits_d  = '0;
          len_d   = 3'd0;
          ovf_d   = 1'b0;
          gap_d   = 3'd0;
        end else if (sym_s) begin
          tclear_d = 1'b1;
          if (len_q < MAX_LEN) begin
            bits_d = append_sym(bits_q, sym_bit_s);
            len_d  = len_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (Timeout) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_EMIT: begin
        // The letter fields are frozen here; symbols and Timeout are ignored.
        if (Go) begin
          state_d = ST_IDLE;
          bits_d  = '0;
          len_d   = 3'd0;
          ovf_d   = 1'b0;
          gap_d   = 3'd0;
        end else if (Letter_ack) begin
          state_d = ST_GAP;
          bits_d  = '0;
          len_d   = 3'd0;
          ovf_d   = 1'b0;
          gap_d   = 3'd1;
        end else begin
          state_d = ST_EMIT;
        end
      end

      ST_GAP: begin
        // gap_q already counts the Timeout that ended the letter.
        if (Go) begin
          state_d = ST_IDLE;
          bits_d  = '0;
          len_d   = 3'd0;
          ovf_d   = 1'b0;
          gap_d   = 3'd0;
        end else if (sym_s) begin
          bits_d   = first_sym(sym_bit_s);
          len_d    = 3'd1;
          ovf_d    = 1'b0;
          gap_d    = 3'd0;
          tclear_d = 1'b1;
          state_d  = ST_COLLECT;
        end else if (Timeout) begin
          if ((gap_q + 3'd1) == GAP_LIMIT) begin
            space_d = 1'b1;
            gap_d   = 3'd0;
            state_d = ST_WAIT_SYM;
          end else begin
            gap_d = gap_q + 3'd1;
          end
        end else begin
          state_d = ST_GAP;
        end
      end

      default: begin
        // Unreachable codes recover to a clean idle.
        state_d = ST_IDLE;
        bits_d  = '0;
        len_d   = 3'd0;
        ovf_d   = 1'b0;
        gap_d   = 3'd0;
      end
    endcase
  end

  // Level outputs are decoded from the next state so they stay registered
  // yet line up with State in the same cycle.
  always_comb begin
    cal_start_d = (state_d == ST_CAL);
    dec_start_d = (state_d == ST_WAIT_SYM) || (state_d == ST_COLLECT) ||
                  (state_d == ST_EMIT)     || (state_d == ST_GAP);
    valid_d     = (state_d == ST_EMIT);
  end

  // State, letter and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      calibrated_q <= 1'b0;
      bits_q       <= '0;
      len_q        <= 3'd0;
      ovf_q        <= 1'b0;
      gap_q        <= 3'd0;
      tclear_q     <= 1'b0;
      space_q      <= 1'b0;
      cal_start_q  <= 1'b0;
      dec_start_q  <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      calibrated_q <= calibrated_d;
      bits_q       <= bits_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      gap_q        <= gap_d;
      tclear_q     <= tclear_d;
      space_q      <= space_d;
      cal_start_q  <= cal_start_d;
      dec_start_q  <= dec_start_d;
      valid_q      <= valid_d;
    end
  end

  assign Cal_Start    = cal_start_q;
  assign Dec_Start    = dec_start_q;
  assign Tclear       = tclear_q;
  assign Letter_bits  = bits_q;
  assign Letter_len   = len_q;
  assign Letter_valid = valid_q;
  assign Overflow     = ovf_q;
  assign Space_valid  = space_q;
  assign State        = state_q;

endmodule

// File: tb/tb_morse_decode_sequencer.sv
module tb_morse_decode_sequencer;

  localparam int MS = 5;
  localparam int WG = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Mode = 1'b0;
  logic Go = 1'b0;
  logic Cal_Done = 1'b0;
  logic Dot = 1'b0;
  logic Dash = 1'b0;
  logic Timeout = 1'b0;
  logic Letter_ack = 1'b0;
  logic Cal_Start, Dec_Start, Tclear, Letter_valid, Overflow, Space_valid;
  logic [MS-1:0] Letter_bits;
  logic [2:0] Letter_len, State;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [MS-1:0] bits;
    logic [2:0]    len;
    logic          ovf;
  } letter_t;

  letter_t exp_q[$];
  int      space_q[$];
  int      tclear_seen = 0;
  int      tclear_exp  = 0;
  logic    prev_valid  = 1'b0;
  letter_t held;

  morse_decode_sequencer #(.MAX_SYM(MS), .WORD_GAP_TO(WG)) dut (
    .Clk(Clk), .Reset(Reset), .Mode(Mode), .Go(Go), .Cal_Done(Cal_Done),
    .Dot(Dot), .Dash(Dash), .Timeout(Timeout), .Letter_ack(Letter_ack),
    .Cal_Start(Cal_Start), .Dec_Start(Dec_Start), .Tclear(Tclear),
    .Letter_bits(Letter_bits), .Letter_len(Letter_len), .Letter_valid(Letter_valid),
    .Overflow(Overflow), .Space_valid(Space_valid), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference letter: first MAX symbols read as a binary number (dash = 1),
  // length clipped at MAX, overflow when more symbols were keyed.
  function automatic letter_t model(input int n, input logic [7:0] syms);
    letter_t r;
    int v;
    v = 0;
    for (int i = 0; i < n; i++) begin
      if (i < MS) v = v * 2 + int'(syms[i]);
    end
    r.bits = v[MS-1:0];
    r.len  = 3'((n < MS) ? n : MS);
    r.ovf  = (n > MS);
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a letter or space.
  initial begin : monitor
    letter_t e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        if (Tclear) tclear_seen++;
        if (Space_valid) begin
          check("space_expected", 32'(space_q.size() > 0), 32'd1);
          if (space_q.size() > 0) void'(space_q.pop_front());
        end
        if (Letter_valid && !prev_valid) begin
          check("letter_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("letter_bits", 32'(Letter_bits), 32'(e.bits));
            check("letter_len", 32'(Letter_len), 32'(e.len));
            check("letter_ovf", 32'(Overflow), 32'(e.ovf));
          end
          held = '{Letter_bits, Letter_len, Overflow};
        end else if (Letter_valid) begin
          check("letter_stable", 32'({Letter_bits, Letter_len, Overflow}), 32'(held));
        end
        prev_valid = Letter_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pulse_go(input logic m);
    Mode = m; Go = 1'b1; tick(); Go = 1'b0;
  endtask

  task automatic pulse_cal(input logic with_go);
    Cal_Done = 1'b1; Go = with_go; tick(); Cal_Done = 1'b0; Go = 1'b0;
  endtask

  task automatic pulse_to();
    Timeout = 1'b1; tick(); Timeout = 1'b0;
  endtask

  // code: 0 = dot, 1 = dash, 2 = dot+dash together
  task automatic send_sym(input int code, input logic with_to);
    Dot = (code != 1); Dash = (code != 0); Timeout = with_to;
    tick();
    Dot = 1'b0; Dash = 1'b0; Timeout = 1'b0;
    tclear_exp++;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!Letter_valid && k < 50) begin
      tick();
      k++;
    end
    check("valid_wait", 32'(Letter_valid), 32'd1);
  endtask

  task automatic do_ack();
    Letter_ack = 1'b1; tick(); Letter_ack = 1'b0;
    check("ack_state", 32'(State), 32'd5);
    check("ack_valid", 32'(Letter_valid), 32'd0);
  endtask

  task automatic send_letter(input int n, input logic [7:0] syms);
    int code;
    exp_q.push_back(model(n, syms));
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 2));
      if (syms[i]) code = ($urandom_range(0, 1) == 0) ? 1 : 2;
      else code = 0;
      send_sym(code, $urandom_range(0, 2) == 0);
    end
    tick($urandom_range(0, 2));
    pulse_to();
    wait_valid();
    tick($urandom_range(0, 6));
    do_ack();
  endtask

  initial begin : stimulus
    int base;
    int n;
    logic [7:0] s;
    logic in_wait;

    // Reset state
    tick(2);
    check("rst_state", 32'(State), 32'd0);
    check("rst_outs", 32'({Cal_Start, Dec_Start, Tclear, Letter_valid, Overflow, Space_valid}), 32'd0);
    check("rst_letter", 32'({Letter_bits, Letter_len}), 32'd0);
    Reset = 1'b1;
    tick();

    // Calibration, abort and priority
    pulse_go(1'b1);
    check("t1_cal_state", 32'(State), 32'd1);
    check("t1_cal_start", 32'(Cal_Start), 32'd1);
    pulse_go(1'b0);
    check("t1_abort_state", 32'(State), 32'd0);
    pulse_go(1'b1);
    check("t1_still_uncal", 32'(State), 32'd1);
    pulse_cal(1'b0);
    check("t1_done_state", 32'(State), 32'd0);
    check("t1_done_calstart", 32'(Cal_Start), 32'd0);
    pulse_go(1'b0);
    check("t1_recal", 32'(State), 32'd1);
    pulse_cal(1'b1);
    check("t1_caldone_wins", 32'(State), 32'd0);
    pulse_go(1'b1);
    tclear_exp++;
    check("t1_wait_state", 32'(State), 32'd2);
    check("t1_tclear", 32'(Tclear), 32'd1);
    check("t1_dec_start", 32'(Dec_Start), 32'd1);
    tick();
    check("t1_tclear_end", 32'(Tclear), 32'd0);

    // Letter "A"
    pulse_to();
    check("t2_wait_ignores_to", 32'(State), 32'd2);
    exp_q.push_back(model(2, 8'b0000_0010));
    send_sym(0, 1'b0);
    send_sym(1, 1'b0);
    pulse_to();
    check("t2_valid_rise", 32'(Letter_valid), 32'd1);
    check("t2_emit_state", 32'(State), 32'd4);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        Dot = 1'b1; Timeout = 1'b1;
      end
      tick();
      Dot = 1'b0; Timeout = 1'b0;
      check("t2_valid_hold", 32'(Letter_valid), 32'd1);
    end
    do_ack();
    check("t2_cleared_len", 32'(Letter_len), 32'd0);

    // Six dashes: overflow
    tick();
    base = tclear_seen;
    exp_q.push_back(model(6, 8'b0011_1111));
    for (int i = 0; i < 6; i++) send_sym(1, 1'b0);
    tick();
    check("t3_six_tclear", 32'(tclear_seen - base), 32'd6);
    check("t3_len", 32'(Letter_len), 32'd5);
    pulse_to();
    check("t3_overflow", 32'(Overflow), 32'd1);
    check("t3_bits", 32'(Letter_bits), 32'h1f);
    do_ack();

    // Word gap, then a gap interrupted by a symbol
    pulse_to();
    check("t4_no_space", 32'(Space_valid), 32'd0);
    check("t4_gap_state", 32'(State), 32'd5);
    space_q.push_back(0);
    pulse_to();
    check("t4_space", 32'(Space_valid), 32'd1);
    check("t4_wait_state", 32'(State), 32'd2);
    tick();
    check("t4_space_end", 32'(Space_valid), 32'd0);
    exp_q.push_back(model(1, 8'b0000_0000));
    send_sym(0, 1'b0);
    pulse_to();
    wait_valid();
    do_ack();
    pulse_to();
    exp_q.push_back(model(3, 8'b0000_0100));
    send_sym(0, 1'b0);
    check("t4_collect", 32'(State), 32'd3);
    check("t4_len1", 32'(Letter_len), 32'd1);
    check("t4_no_space2", 32'(Space_valid), 32'd0);

    // Simultaneous events
    send_sym(0, 1'b1);
    check("t5_sym_wins", 32'(State), 32'd3);
    check("t5_len2", 32'(Letter_len), 32'd2);
    check("t5_tclear", 32'(Tclear), 32'd1);
    send_sym(2, 1'b0);
    check("t5_len3", 32'(Letter_len), 32'd3);
    check("t5_bits", 32'(Letter_bits), 32'd1);
    pulse_to();
    wait_valid();
    do_ack();

    // Go aborts in COLLECT and in EMIT; calibration retained
    send_sym(1, 1'b0);
    pulse_go(1'b1);
    check("abort_collect_state", 32'(State), 32'd0);
    check("abort_collect_len", 32'(Letter_len), 32'd0);
    check("abort_dec_start", 32'(Dec_Start), 32'd0);
    pulse_go(1'b1);
    tclear_exp++;
    check("abort_keeps_cal", 32'(State), 32'd2);
    exp_q.push_back(model(2, 8'b0000_0001));
    send_sym(1, 1'b0);
    send_sym(0, 1'b0);
    pulse_to();
    tick();
    pulse_go(1'b0);
    check("abort_emit_valid", 32'(Letter_valid), 32'd0);
    check("abort_emit_ovf", 32'(Overflow), 32'd0);
    pulse_go(1'b1);
    tclear_exp++;
    check("abort_emit_rewait", 32'(State), 32'd2);

    // Asynchronous reset while presenting a letter
    exp_q.push_back(model(1, 8'b0000_0001));
    send_sym(1, 1'b0);
    pulse_to();
    check("t6_emit", 32'(State), 32'd4);
    tick();
    Reset = 1'b0;
    #1;
    check("t6_async_valid", 32'(Letter_valid), 32'd0);
    check("t6_async_state", 32'(State), 32'd0);
    check("t6_async_len", 32'(Letter_len), 32'd0);
    tick(2);
    Reset = 1'b1;
    tick();
    pulse_go(1'b1);
    check("t6_cal_lost", 32'(State), 32'd1);
    check("t6_cal_start", 32'(Cal_Start), 32'd1);
    pulse_cal(1'b0);
    pulse_go(1'b1);
    tclear_exp++;
    check("t6_wait", 32'(State), 32'd2);

    // Randomised letters and gaps
    in_wait = 1'b1;
    for (int l = 0; l < 40; l++) begin
      n = $urandom_range(1, 7);
      s = 8'($urandom);
      if (in_wait) begin
        repeat ($urandom_range(0, 2)) begin
          pulse_to();
          check("rnd_wait_ignores_to", 32'(State), 32'd2);
        end
      end
      send_letter(n, s);
      if ($urandom_range(0, 1) == 1) begin
        repeat (WG - 2) pulse_to();
        space_q.push_back(l);
        pulse_to();
        check("rnd_word_gap", 32'(State), 32'd2);
        in_wait = 1'b1;
      end else begin
        repeat ($urandom_range(0, WG - 2)) pulse_to();
        check("rnd_letter_gap", 32'(State), 32'd5);
        in_wait = 1'b0;
      end
    end

    tick(3);
    check("end_letters_drained", 32'(exp_q.size()), 32'd0);
    check("end_spaces_drained", 32'(space_q.size()), 32'd0);
    check("end_tclear_count", 32'(tclear_seen), 32'(tclear_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
